// File: rtl/lpc_pkg.sv
// Shared LPC constants, the phase enum and the window-hit helper.
package lpc_pkg;

    localparam int STATE_W = 11;

    localparam logic [3:0] CYC_IO_RD = 4'h0;
    localparam logic [3:0] CYC_IO_WR = 4'h2;
    localparam logic [3:0] LAD_START = 4'h0;

    localparam int ST_IDLE    = 0;
    localparam int ST_CYCTYPE = 1;
    localparam int ST_ADDR    = 2;
    localparam int ST_WDATA   = 3;
    localparam int ST_HTAR0   = 4;
    localparam int ST_HTAR1   = 5;
    localparam int ST_SYNC    = 6;
    localparam int ST_RDATA_L = 7;
    localparam int ST_RDATA_H = 8;
    localparam int ST_PTAR0   = 9;
    localparam int ST_PTAR1   = 10;

    // Encoding equals the bit position in the State vector.
    typedef enum logic [3:0] {
        S_IDLE    = 4'(ST_IDLE),
        S_CYCTYPE = 4'(ST_CYCTYPE),
        S_ADDR    = 4'(ST_ADDR),
        S_WDATA   = 4'(ST_WDATA),
        S_HTAR0   = 4'(ST_HTAR0),
        S_HTAR1   = 4'(ST_HTAR1),
        S_SYNC    = 4'(ST_SYNC),
        S_RDATA_L = 4'(ST_RDATA_L),
        S_RDATA_H = 4'(ST_RDATA_H),
        S_PTAR0   = 4'(ST_PTAR0),
        S_PTAR1   = 4'(ST_PTAR1)
    } lpcState_t;

    function automatic logic addrHit(input logic [7:0] addrHi, input logic [7:0] baseHi);
        return addrHi == baseHi;
    endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// Nibble-wide shift register (MSB nibble first) with parallel load and clear.
import lpc_pkg::*;

module lpc_nibble_shift #(
    parameter int WIDTH = 16
) (
    input  logic             LpcClock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             shift,
    input  logic [3:0]       nibble,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge LpcClock) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= loadVal;
        end else if (shift) begin
            q <= {q[WIDTH-5:0], nibble};
        end
    end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Decodes host-initiated LPC I/O read/write cycles into phase, opcode, offset
// and write-data outputs for a 256-byte I/O window.
import lpc_pkg::*;

module lpc_cycle_decoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0A00
) (
    input  logic               LpcClock,
    input  logic               LpcReset,
    input  logic               LpcFrame_n,
    input  logic [3:0]         LpcAdIn,
    output logic [STATE_W-1:0] State,
    output logic               Opcode,
    output logic [7:0]         AddrReg,
    output logic [7:0]         WrData,
    output logic               WrStrobe,
    output logic               RdStrobe,
    output logic               Hit
);

    lpcState_t   curState, nextState;
    logic [1:0]  nibCnt;
    logic [11:0] addrHist;
    logic [15:0] fullAddr;
    logic        hitNow;
    logic        isStart;
    logic        addrShift;
    logic        wrLoad;
    logic [7:0]  wrLoadVal;

    // Only the three leading nibbles need storing; the fourth is on LAD
    // during the last address cycle.
    assign fullAddr  = {addrHist, LpcAdIn};
    assign hitNow    = addrHit(fullAddr[15:8], BASE_ADDR[15:8]);
    assign isStart   = !LpcFrame_n && (LpcAdIn == LAD_START);
    assign addrShift = LpcFrame_n && (curState == S_ADDR);
    assign wrLoad    = LpcFrame_n && (curState == S_WDATA);
    assign wrLoadVal = nibCnt[0] ? {LpcAdIn, WrData[3:0]} : {WrData[7:4], LpcAdIn};

    lpc_nibble_shift #(.WIDTH(12)) addrShiftReg (
        .LpcClock (LpcClock),
        .clear    (LpcReset),
        .load     (1'b0),
        .loadVal  (12'h000),
        .shift    (addrShift),
        .nibble   (LpcAdIn),
        .q        (addrHist)
    );

    lpc_nibble_shift #(.WIDTH(8)) dataShiftReg (
        .LpcClock (LpcClock),
        .clear    (LpcReset),
        .load     (wrLoad),
        .loadVal  (wrLoadVal),
        .shift    (1'b0),
        .nibble   (LpcAdIn),
        .q        (WrData)
    );

    always_ff @(posedge LpcClock) begin
        if (LpcReset) begin
            curState <= S_IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        if (!LpcFrame_n) begin
            nextState = isStart ? S_CYCTYPE : S_IDLE;
        end else begin
            case (curState)
                S_IDLE:    nextState = S_IDLE;
                S_CYCTYPE: nextState = (LpcAdIn == CYC_IO_RD || LpcAdIn == CYC_IO_WR) ? S_ADDR : S_IDLE;
                S_ADDR: begin
                    if (nibCnt == 2'd0) begin
                        nextState = !hitNow ? S_IDLE : (Opcode ? S_WDATA : S_HTAR0);
                    end
                end
                S_WDATA:   nextState = (nibCnt == 2'd1) ? S_HTAR0 : S_WDATA;
                S_HTAR0:   nextState = S_HTAR1;
                S_HTAR1:   nextState = S_SYNC;
                S_SYNC:    nextState = Opcode ? S_PTAR0 : S_RDATA_L;
                S_RDATA_L: nextState = S_RDATA_H;
                S_RDATA_H: nextState = S_PTAR0;
                S_PTAR0:   nextState = S_PTAR1;
                S_PTAR1:   nextState = S_IDLE;
                default:   nextState = S_IDLE;
            endcase
        end
    end

    always_comb begin
        State    = (STATE_W'(1) << curState) & {{5{Hit}}, 6'h3F};
        WrStrobe = (curState == S_SYNC) && Opcode && Hit;
        RdStrobe = (curState == S_HTAR0) && !Opcode && Hit;
    end

    // Down-count through the address nibbles, up-count through the data nibbles.
    always_ff @(posedge LpcClock) begin
        if (LpcReset) begin
            nibCnt  <= 2'd0;
            Opcode  <= 1'b0;
            AddrReg <= 8'h00;
            Hit     <= 1'b0;
        end else if (!LpcFrame_n) begin
            if (isStart) begin
                Hit <= 1'b0;
            end
        end else begin
            case (curState)
                S_CYCTYPE: begin
                    if (LpcAdIn == CYC_IO_RD || LpcAdIn == CYC_IO_WR) begin
                        Opcode <= (LpcAdIn == CYC_IO_WR);
                    end
                    nibCnt <= 2'd3;
                end
                S_ADDR: begin
                    if (nibCnt == 2'd0) begin
                        AddrReg <= fullAddr[7:0];
                        Hit     <= hitNow;
                        nibCnt  <= 2'd0;
                    end else begin
                        nibCnt <= nibCnt - 2'd1;
                    end
                end
                S_WDATA: nibCnt <= nibCnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Bench for lpc_cycle_decoder: table-driven phase model plus directed and random cycles.
module tb_lpc_cycle_decoder;

    logic        LpcClock = 1'b0;
    logic        LpcReset;
    logic        LpcFrame_n;
    logic [3:0]  LpcAdIn;
    logic [10:0] State;
    logic        Opcode;
    logic [7:0]  AddrReg;
    logic [7:0]  WrData;
    logic        WrStrobe;
    logic        RdStrobe;
    logic        Hit;

    always #15 LpcClock = ~LpcClock;

    lpc_cycle_decoder #(.BASE_ADDR(16'h0A00)) dut (
        .LpcClock   (LpcClock),
        .LpcReset   (LpcReset),
        .LpcFrame_n (LpcFrame_n),
        .LpcAdIn    (LpcAdIn),
        .State      (State),
        .Opcode     (Opcode),
        .AddrReg    (AddrReg),
        .WrData     (WrData),
        .WrStrobe   (WrStrobe),
        .RdStrobe   (RdStrobe),
        .Hit        (Hit)
    );

    int tests = 0;
    int fails = 0;

    // Model: position k counted from the CYCTYPE cycle, phase looked up per cycle type.
    int wrSeq [12] = '{1, 2, 2, 2, 2, 3, 3, 4, 5, 6, 9, 10};
    int rdSeq [12] = '{1, 2, 2, 2, 2, 4, 5, 6, 7, 8, 9, 10};
    bit mActive = 0;
    int mK = 0;
    bit mWr = 0;
    int mAddr = 0;
    bit mHit = 0;
    bit mOp = 0;
    int mAddrReg = 0;
    int mWrData = 0;

    bit checkEn = 0;
    int wrPulses = 0;
    int rdPulses = 0;
    int phaseLog = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int expIdx();
        if (!mActive) return 0;
        return mWr ? wrSeq[mK] : rdSeq[mK];
    endfunction

    function automatic int onehotIdx(input logic [10:0] v);
        for (int i = 0; i < 11; i++) if (v[i]) return i;
        return 15;
    endfunction

    task automatic modelEdge();
        if (LpcReset) begin
            mActive = 0; mOp = 0; mAddrReg = 0; mWrData = 0; mHit = 0;
        end else if (!LpcFrame_n) begin
            if (LpcAdIn == 4'h0) begin mActive = 1; mK = 0; mHit = 0; end
            else mActive = 0;
        end else if (mActive) begin
            if (mK == 0) begin
                if (LpcAdIn == 4'h0 || LpcAdIn == 4'h2) begin
                    mWr = (LpcAdIn == 4'h2); mOp = mWr; mAddr = 0; mK = 1;
                end else mActive = 0;
            end else begin
                if (mK <= 4) begin
                    mAddr = mAddr * 16 + int'(LpcAdIn);
                    if (mK == 4) begin
                        mAddrReg = mAddr % 256;
                        mHit = (mAddr / 256) == 'h0A;
                        if (!mHit) mActive = 0;
                    end
                end else if (mWr && mK == 5) mWrData = (mWrData & 'hF0) | int'(LpcAdIn);
                else if (mWr && mK == 6) mWrData = (mWrData & 'h0F) | (int'(LpcAdIn) * 16);
                mK++;
                if (mK >= 12) mActive = 0;
            end
        end
    endtask

    always @(negedge LpcClock) begin
        if (checkEn) begin
            chk("State", int'(State), 1 << expIdx());
            chk("Opcode", int'(Opcode), int'(mOp));
            chk("AddrReg", int'(AddrReg), mAddrReg);
            chk("WrData", int'(WrData), mWrData);
            chk("Hit", int'(Hit), int'(mHit));
            chk("WrStrobe", int'(WrStrobe), int'(mActive && mWr && expIdx() == 6));
            chk("RdStrobe", int'(RdStrobe), int'(mActive && !mWr && expIdx() == 4));
            if (WrStrobe) wrPulses++;
            if (RdStrobe) rdPulses++;
            if (|State[10:6]) phaseLog = phaseLog * 16 + onehotIdx(State);
        end
    end

    task automatic step(input bit fr, input logic [3:0] lad, input bit rst);
        LpcFrame_n = fr; LpcAdIn = lad; LpcReset = rst;
        @(posedge LpcClock);
        modelEdge();
        @(negedge LpcClock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    task automatic hostCycle(input logic [3:0] cyc, input logic [15:0] a,
                             input logic [7:0] d, input bit withData);
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, cyc, 1'b0);
        step(1'b1, a[15:12], 1'b0);
        step(1'b1, a[11:8], 1'b0);
        step(1'b1, a[7:4], 1'b0);
        step(1'b1, a[3:0], 1'b0);
        if (withData) begin
            step(1'b1, d[3:0], 1'b0);
            step(1'b1, d[7:4], 1'b0);
        end
    endtask

    task automatic clearLogs();
        wrPulses = 0; rdPulses = 0; phaseLog = 0;
    endtask

    task automatic randomCycle();
        logic [3:0]  nibs [$];
        logic [3:0]  cyc;
        logic [15:0] a;
        logic [7:0]  d;
        int r;
        r = $urandom_range(0, 19);
        cyc = (r < 9) ? 4'h0 : (r < 18) ? 4'h2 : 4'($urandom_range(0, 15));
        a = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 4) < 3) a[15:8] = 8'h0A;
        d = 8'($urandom_range(0, 255));
        nibs.push_back(cyc);
        nibs.push_back(a[15:12]); nibs.push_back(a[11:8]);
        nibs.push_back(a[7:4]);   nibs.push_back(a[3:0]);
        if (cyc == 4'h2) begin nibs.push_back(d[3:0]); nibs.push_back(d[7:4]); end
        step(1'b0, 4'h0, 1'b0);
        foreach (nibs[i]) begin
            r = $urandom_range(0, 99);
            if (r < 3) step(1'b0, 4'($urandom_range(0, 3)), 1'b0);
            else if (r == 3) step(1'b1, nibs[i], 1'b1);
            else step(1'b1, nibs[i], 1'b0);
        end
        idle($urandom_range(0, 12));
    endtask

    initial begin
        LpcReset = 1'b1; LpcFrame_n = 1'b1; LpcAdIn = 4'h0;
        @(negedge LpcClock);
        step(1'b1, 4'h0, 1'b1);
        step(1'b1, 4'h0, 1'b1);
        checkEn = 1;
        chk("reset State", int'(State), 1);
        chk("reset AddrReg", int'(AddrReg), 0);
        chk("reset WrData", int'(WrData), 0);
        chk("reset Opcode", int'(Opcode), 0);
        chk("reset Hit", int'(Hit), 0);
        idle(2);

        // IO write 0x0A05 <- 0x3C
        clearLogs();
        hostCycle(4'h2, 16'h0A05, 8'h3C, 1'b1);
        idle(8);
        chk("wr pulses", wrPulses, 1);
        chk("wr no rd", rdPulses, 0);
        chk("wr AddrReg", int'(AddrReg), 'h05);
        chk("wr WrData", int'(WrData), 'h3C);
        chk("wr Opcode", int'(Opcode), 1);
        chk("wr phases", phaseLog, 'h69A);
        chk("wr idle", int'(State), 1);

        // IO read 0x0A12
        clearLogs();
        hostCycle(4'h0, 16'h0A12, 8'h00, 1'b0);
        chk("rd HTAR0 strobe", int'(RdStrobe), 1);
        idle(8);
        chk("rd pulses", rdPulses, 1);
        chk("rd phases", phaseLog, 'h6789A);
        chk("rd Opcode", int'(Opcode), 0);
        chk("rd AddrReg", int'(AddrReg), 'h12);
        chk("rd idle", int'(State), 1);

        // Miss read 0x0B00
        clearLogs();
        hostCycle(4'h0, 16'h0B00, 8'h00, 1'b0);
        chk("miss idle", int'(State), 1);
        chk("miss Hit", int'(Hit), 0);
        idle(8);
        chk("miss phases", phaseLog, 0);
        chk("miss pulses", wrPulses + rdPulses, 0);

        // Abort in 3rd address nibble, then a clean write 0x0A20 <- 0x55
        clearLogs();
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'hA, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        chk("abort CYCTYPE", int'(State), 2);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h0, 1'b0); step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'h2, 1'b0); step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h5, 1'b0); step(1'b1, 4'h5, 1'b0);
        idle(8);
        chk("abort wr pulses", wrPulses, 1);
        chk("abort WrData", int'(WrData), 'h55);
        chk("abort AddrReg", int'(AddrReg), 'h20);

        // Memory cycle type and a non-START frame
        clearLogs();
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        chk("mem idle", int'(State), 1);
        step(1'b0, 4'hF, 1'b0);
        chk("frame F idle", int'(State), 1);
        idle(8);
        chk("mem pulses", wrPulses + rdPulses, 0);

        // Reset during WDATA
        clearLogs();
        hostCycle(4'h2, 16'h0A33, 8'h00, 1'b0);
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h9, 1'b1);
        chk("rst State", int'(State), 1);
        chk("rst WrData", int'(WrData), 0);
        chk("rst AddrReg", int'(AddrReg), 0);
        idle(8);
        chk("rst no strobe", wrPulses, 0);

        for (int t = 0; t < 400; t++) randomCycle();
        idle(14);

        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
